// File: rtl/score_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : score_scheduler
// Purpose  : Collision-event scheduler and score accumulator. Round-robin
//            arbitration of LANES colored hit sources into a small event FIFO,
//            drained one event per cycle into a saturating score register.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   system clock, rising-edge
//   rst_n       in   asynchronous active-low reset
//   hit_valid   in   [LANES]     per-lane event request (held until accepted)
//   hit_color   in   [2*LANES]   per-lane color, lane i at [2i+1:2i]
//   hit_ready   out  [LANES]     one-hot/zero accept
//   clear       in   synchronous new-game clear (score, FIFO, arbiter)
//   pause       in   stall FIFO drain
//   score       out  [SCORE_W]   current score
//   hiscore     out  [SCORE_W]   best score since reset (0 if feature off)
//   fifo_level  out  occupied FIFO entries
//   busy        out  FIFO non-empty
// Build option
//   SCORE_HISCORE_EN : when defined, builds the high-score register.
// ============================================================================
module score_scheduler #(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int SCORE_W    = 7,
    parameter int GREEN_PTS  = 2,
    parameter int BLUE_PTS   = 5,
    parameter int RED_PEN    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LANES-1:0]              hit_valid,
    input  logic [2*LANES-1:0]            hit_color,
    output logic [LANES-1:0]              hit_ready,
    input  logic                          clear,
    input  logic                          pause,
    output logic [SCORE_W-1:0]            score,
    output logic [SCORE_W-1:0]            hiscore,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int c_lw = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_pw = $clog2(FIFO_DEPTH);

    localparam logic [c_lw-1:0]    c_last_lane = c_lw'(LANES - 1);
    localparam logic [c_pw:0]      c_depth     = (c_pw + 1)'(FIFO_DEPTH);
    localparam logic [SCORE_W:0]   c_green     = (SCORE_W + 1)'(GREEN_PTS);
    localparam logic [SCORE_W:0]   c_blue      = (SCORE_W + 1)'(BLUE_PTS);
    localparam logic [SCORE_W:0]   c_red       = (SCORE_W + 1)'(RED_PEN);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_lw-1:0]    r_rr;
    logic [1:0]         r_mem [FIFO_DEPTH];
    logic [c_pw-1:0]    r_wptr;
    logic [c_pw-1:0]    r_rptr;
    logic [c_pw:0]      r_level;
    logic               r_busy;
    logic [SCORE_W-1:0] r_score;

    // ------------------------------------------------------------------------
    // Round-robin arbiter: first valid lane at or after r_rr, wrapping.
    // ------------------------------------------------------------------------
    logic [c_lw-1:0] w_gnt;
    logic [c_lw-1:0] w_cand;
    logic            w_found;

    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_rr;
        w_cand  = r_rr;
        for (int i = 0; i < LANES; i++) begin
            if (!w_found && hit_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
            w_cand = (w_cand == c_last_lane) ? '0 : w_cand + 1'b1;
        end
    end

    // Full is judged on the registered level only: a pop in the same cycle
    // does not open a slot for a push.
    logic w_full;
    logic w_empty;
    assign w_full  = (r_level == c_depth);
    assign w_empty = (r_level == '0);

    // rst_n gates the grant so no handshake can complete while reset is held.
    always_comb begin
        hit_ready = '0;
        if (rst_n && w_found && !w_full && !clear) begin
            hit_ready[w_gnt] = 1'b1;
        end
    end

    logic       w_accept;
    logic [1:0] w_color;
    logic       w_push;
    logic       w_pop;

    assign w_accept = |hit_ready;
    assign w_color  = hit_color[{w_gnt, 1'b0} +: 2];
    // Color 00 completes the handshake but carries no points, so it is
    // not queued.
    assign w_push   = w_accept && (w_color != 2'b00);
    assign w_pop    = !w_empty && !pause && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= '0;
        end else if (clear) begin
            r_rr <= '0;
        end else if (w_accept) begin
            r_rr <= (w_gnt == c_last_lane) ? '0 : w_gnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Event FIFO (color only)
    // ------------------------------------------------------------------------
    logic [c_pw:0] w_level_nxt;

    always_comb begin
        w_level_nxt = r_level;
        if (clear) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers/level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (clear) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_busy  <= (w_level_nxt != '0);
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator: one extra bit catches both overflow and borrow, so a set
    // top bit means "clamp" - to zero for a penalty, to max for a reward.
    // ------------------------------------------------------------------------
    logic [1:0]         w_head;
    logic [SCORE_W:0]   w_ext;
    logic [SCORE_W:0]   w_arith;
    logic [SCORE_W-1:0] w_scored;
    logic [SCORE_W-1:0] w_score_nxt;

    assign w_head = r_mem[r_rptr];
    assign w_ext  = {1'b0, r_score};

    always_comb begin
        case (w_head)
            2'b01:   w_arith = w_ext + c_green;
            2'b10:   w_arith = w_ext + c_blue;
            2'b11:   w_arith = w_ext - c_red;
            default: w_arith = w_ext;
        endcase
        w_scored = w_arith[SCORE_W-1:0];
        if (w_arith[SCORE_W]) begin
            w_scored = (w_head == 2'b11) ? '0 : '1;
        end
    end

    always_comb begin
        w_score_nxt = r_score;
        if (clear) begin
            w_score_nxt = '0;
        end else if (w_pop) begin
            w_score_nxt = w_scored;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score <= '0;
        end else begin
            r_score <= w_score_nxt;
        end
    end

`ifdef SCORE_HISCORE_EN
    // Tracks the value score is about to take, so hiscore and score move on
    // the same edge. Only reset clears it; a new game keeps the record.
    logic [SCORE_W-1:0] r_hiscore;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hiscore <= '0;
        end else if (w_score_nxt > r_hiscore) begin
            r_hiscore <= w_score_nxt;
        end
    end

    assign hiscore = r_hiscore;
`else
    assign hiscore = '0;
`endif

    assign score      = r_score;
    assign fifo_level = r_level;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_score_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_scheduler
// Purpose  : Self-checking bench for score_scheduler. A reference model keeps
//            a queue of accepted colors (pushed on handshake, popped on drain)
//            and an expected score/arbiter pointer; scenario tasks compare the
//            DUT against the model and against hand-derived constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_scheduler;

    localparam int LANES      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int SCORE_W    = 7;
    localparam int SMAX       = (1 << SCORE_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [LANES-1:0]     hit_valid = '0;
    logic [2*LANES-1:0]   hit_color = '0;
    logic [LANES-1:0]     hit_ready;
    logic                 clear = 1'b0;
    logic                 pause = 1'b0;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   hiscore;
    logic [2:0]           fifo_level;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;

    score_scheduler #(
        .LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH), .SCORE_W(SCORE_W),
        .GREEN_PTS(2), .BLUE_PTS(5), .RED_PEN(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hit_valid(hit_valid), .hit_color(hit_color),
        .hit_ready(hit_ready), .clear(clear), .pause(pause), .score(score),
        .hiscore(hiscore), .fifo_level(fifo_level), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Reference model (scoreboard)
    // ------------------------------------------------------------------------
    logic [1:0] m_q[$];
    int m_rr    = 0;
    int m_score = 0;
    int m_hi    = 0;

    function automatic logic [LANES-1:0] model_ready();
        logic [LANES-1:0] r;
        r = '0;
        if (!rst_n || clear || m_q.size() >= FIFO_DEPTH) return r;
        for (int k = 0; k < LANES; k++) begin
            int l;
            l = (m_rr + k) % LANES;
            if (hit_valid[l]) begin
                r[l] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_rr    = 0;
            m_score = 0;
            m_hi    = 0;
        end else begin
            logic [LANES-1:0] rdy;
            logic [1:0]       c;
            rdy = model_ready();
            if (clear) begin
                m_q.delete();
                m_score = 0;
                m_rr    = 0;
            end else begin
                if (m_q.size() > 0 && !pause) begin
                    c = m_q.pop_front();
                    case (c)
                        2'b01:   m_score = (m_score + 2 > SMAX) ? SMAX : m_score + 2;
                        2'b10:   m_score = (m_score + 5 > SMAX) ? SMAX : m_score + 5;
                        2'b11:   m_score = (m_score < 3) ? 0 : m_score - 3;
                        default: m_score = m_score;
                    endcase
                end
                for (int l = 0; l < LANES; l++) begin
                    if (rdy[l]) begin
                        m_rr = (l + 1) % LANES;
                        if (hit_color[2*l +: 2] != 2'b00) m_q.push_back(hit_color[2*l +: 2]);
                    end
                end
            end
`ifdef SCORE_HISCORE_EN
            if (m_score > m_hi) m_hi = m_score;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic send(input int lane, input logic [1:0] col, output bit ok);
        logic [LANES-1:0] r;
        ok = 1'b0;
        hit_color[2*lane +: 2] = col;
        hit_valid[lane] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            r = hit_ready;
            tick();
            if (r[lane]) ok = 1'b1;
        end
        hit_valid[lane] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && busy; i++) tick();
    endtask

    function automatic int exp_hi(input int v);
`ifdef SCORE_HISCORE_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        hit_valid = 4'b0001;
        hit_color = 8'b0000_0001;
        repeat (2) tick();
        n_tests++; if (score !== '0)      begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
        n_tests++; if (hiscore !== '0)    begin n_fail++; $display("FAIL reset_hiscore: got %0d want 0", hiscore); end
        n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_tests++; if (hit_ready !== '0)  begin n_fail++; $display("FAIL reset_ready: got %b want 0000", hit_ready); end
        hit_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_green();
        hit_color = 8'b0000_0001;
        hit_valid = 4'b0001;
        #1;
        n_tests++; if (hit_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", hit_ready); end
        tick();
        hit_valid = '0;
        n_tests++; if (busy !== 1'b1 || fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_queued: got busy=%0b level=%0d want busy=1 level=1", busy, fifo_level); end
        n_tests++; if (score !== 7'd0) begin n_fail++; $display("FAIL single_latency: got %0d want 0", score); end
        tick();
        n_tests++; if (score !== 7'd2) begin n_fail++; $display("FAIL single_score: got %0d want 2", score); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_pulse: got %0b want 0", busy); end
    endtask

    task automatic test_color_zero();
        hit_color = 8'b0000_0000;
        hit_valid = 4'b0001;
        #1;
        n_tests++; if (hit_ready !== 4'b0001) begin n_fail++; $display("FAIL zero_ready: got %b want 0001", hit_ready); end
        tick();
        hit_valid = '0;
        n_tests++; if (fifo_level !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_not_queued: got level=%0d busy=%0b want 0/0", fifo_level, busy); end
        tick();
        n_tests++; if (score !== 7'd2) begin n_fail++; $display("FAIL zero_score: got %0d want 2", score); end
    endtask

    task automatic test_back_to_back();
        logic [LANES-1:0] r;
        do_clear();
        n_tests++; if (score !== 7'd0 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL b2b_clear: got score=%0d level=%0d want 0/0", score, fifo_level); end
        hit_color = {2'b10, 2'b01, 2'b10, 2'b01};
        hit_valid = 4'b1111;
        for (int k = 0; k < LANES; k++) begin
            #1;
            r = hit_ready;
            n_tests++; if (r !== 4'(1 << k)) begin n_fail++; $display("FAIL b2b_order%0d: got %b want %b", k, r, 4'(1 << k)); end
            tick();
            hit_valid = hit_valid & ~r;
            n_tests++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL b2b_level%0d: got %0d want 1", k, fifo_level); end
        end
        hit_valid = '0;
        drain();
        n_tests++; if (score !== 7'd14) begin n_fail++; $display("FAIL b2b_score: got %0d want 14", score); end
        n_tests++; if (score !== 7'(m_score)) begin n_fail++; $display("FAIL b2b_model: got %0d want %0d", score, m_score); end
    endtask

    task automatic test_saturate();
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        do_clear();
        for (int i = 0; i < 24; i++) begin send(3, 2'b10, ok); all_ok &= ok; end
        for (int i = 0; i < 3; i++)  begin send(3, 2'b01, ok); all_ok &= ok; end
        drain();
        n_tests++; if (score !== 7'd126) begin n_fail++; $display("FAIL sat_pre: got %0d want 126", score); end
        send(3, 2'b10, ok); all_ok &= ok;
        drain();
        n_tests++; if (score !== 7'd127) begin n_fail++; $display("FAIL sat_max: got %0d want 127", score); end
        n_tests++; if (hiscore !== 7'(exp_hi(127))) begin n_fail++; $display("FAIL sat_hiscore: got %0d want %0d", hiscore, exp_hi(127)); end
        do_clear();
        send(3, 2'b01, ok); all_ok &= ok;
        drain();
        send(3, 2'b11, ok); all_ok &= ok;
        drain();
        n_tests++; if (score !== 7'd0) begin n_fail++; $display("FAIL floor: got %0d want 0", score); end
        do_clear();
        send(3, 2'b10, ok); all_ok &= ok;
        send(3, 2'b10, ok); all_ok &= ok;
        drain();
        n_tests++; if (score !== 7'd10) begin n_fail++; $display("FAIL pen_pre: got %0d want 10", score); end
        send(3, 2'b11, ok); all_ok &= ok;
        drain();
        n_tests++; if (score !== 7'd7) begin n_fail++; $display("FAIL pen_sub: got %0d want 7", score); end
        n_tests++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL sat_handshake: got %0b want 1 (send timed out)", all_ok); end
    endtask

    task automatic test_pause();
        logic [LANES-1:0] r;
        int acc;
        do_clear();
        acc = 0;
        pause = 1'b1;
        hit_color = 8'b0000_0100;
        hit_valid = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r = hit_ready;
            n_tests++; if (r !== model_ready()) begin n_fail++; $display("FAIL pause_ready%0d: got %b want %b", i, r, model_ready()); end
            tick();
            if (r[1]) acc++;
        end
        n_tests++; if (acc !== 4) begin n_fail++; $display("FAIL pause_accepts: got %0d want 4", acc); end
        n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL pause_level: got %0d want 4", fifo_level); end
        n_tests++; if (hit_ready !== '0) begin n_fail++; $display("FAIL pause_full_ready: got %b want 0000", hit_ready); end
        n_tests++; if (score !== 7'd0) begin n_fail++; $display("FAIL pause_frozen: got %0d want 0", score); end
        pause = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            r = hit_ready;
            tick();
            if (r[1]) acc++;
            if (acc >= 6) hit_valid = '0;
            n_tests++; if (score !== 7'(2 * k)) begin n_fail++; $display("FAIL pause_drain%0d: got %0d want %0d", k, score, 2 * k); end
        end
        hit_valid = '0;
        drain();
        n_tests++; if (acc !== 6 || score !== 7'd12) begin n_fail++; $display("FAIL pause_final: got acc=%0d score=%0d want 6/12", acc, score); end
    endtask

    task automatic test_clear();
        bit ok;
        bit all_ok;
        logic [LANES-1:0] r;
        all_ok = 1'b1;
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin send(2, 2'b01, ok); all_ok &= ok; end
        n_tests++; if (fifo_level !== 3'd3 || all_ok !== 1'b1) begin n_fail++; $display("FAIL clr_pre_level: got %0d ok=%0b want 3 ok=1", fifo_level, all_ok); end
        hit_valid = 4'b0100;
        clear = 1'b1;
        #1;
        n_tests++; if (hit_ready !== '0) begin n_fail++; $display("FAIL clr_ready: got %b want 0000", hit_ready); end
        tick();
        clear = 1'b0;
        hit_valid = '0;
        pause = 1'b0;
        n_tests++; if (fifo_level !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_flush: got level=%0d busy=%0b want 0/0", fifo_level, busy); end
        n_tests++; if (score !== 7'd0) begin n_fail++; $display("FAIL clr_score: got %0d want 0", score); end
        n_tests++; if (hiscore !== 7'(exp_hi(127))) begin n_fail++; $display("FAIL clr_hiscore: got %0d want %0d", hiscore, exp_hi(127)); end
        hit_color = 8'b0101_0101;
        hit_valid = 4'b1010;
        #1;
        r = hit_ready;
        n_tests++; if (r !== 4'b0010) begin n_fail++; $display("FAIL clr_rr: got %b want 0010", r); end
        for (int i = 0; i < 4 && hit_valid != '0; i++) begin
            @(negedge clk);
            r = hit_ready;
            tick();
            hit_valid = hit_valid & ~r;
        end
        hit_valid = '0;
        drain();
        n_tests++; if (score !== 7'(m_score) || score !== 7'd4) begin n_fail++; $display("FAIL clr_after: got %0d want 4 (model %0d)", score, m_score); end
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        do_clear();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) send(0, 2'b10, ok);
        pause = 1'b0;
        tick();
        n_tests++; if (score !== 7'd5 || fifo_level !== 3'd2) begin n_fail++; $display("FAIL rst_pre: got score=%0d level=%0d want 5/2", score, fifo_level); end
        hit_color = 8'b0000_0010;
        hit_valid = 4'b0001;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if (score !== '0 || fifo_level !== '0 || busy !== 1'b0 || hiscore !== '0) begin
            n_fail++; $display("FAIL rst_async: got score=%0d level=%0d busy=%0b hi=%0d want all 0", score, fifo_level, busy, hiscore); end
        n_tests++; if (hit_ready !== '0) begin n_fail++; $display("FAIL rst_async_ready: got %b want 0000", hit_ready); end
        tick();
        n_tests++; if (score !== '0 || fifo_level !== '0) begin n_fail++; $display("FAIL rst_hold: got score=%0d level=%0d want 0/0", score, fifo_level); end
        hit_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_tests++; if (score !== '0 || fifo_level !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_release: got score=%0d level=%0d busy=%0b want 0", score, fifo_level, busy); end
    endtask

    initial begin
        test_reset();
        test_single_green();
        test_color_zero();
        test_back_to_back();
        test_saturate();
        test_pause();
        test_clear();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
